// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes and debounces three raw buttons, then turns
// press events into single-cycle strobes. Drop fires once per press. Right and
// left also auto-repeat while held. Holding right and left together is treated
// as a conflict and produces no movement at all.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_RATE     = 3750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_raw,      // bit0 drop, bit1 right, bit2 left
    output logic       drop_pulse,
    output logic       right_pulse,
    output logic       left_pulse,
    output logic [2:0] btn_level
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_e;

    // Synchronizer
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    // Debounce
    logic [DbW-1:0] db_cnt_q [3];
    logic [DbW-1:0] db_cnt_d [3];
    logic [2:0]     level_q;
    logic [2:0]     level_d;

    // Edge detection
    logic [2:0] level_dly_q;
    logic [2:0] rise_q;

    // Repeat FSMs: index 0 is right (button bit1), index 1 is left (button bit2)
    rep_state_e      st_q      [2];
    rep_state_e      st_d      [2];
    logic [RepW-1:0] rep_cnt_q [2];
    logic [RepW-1:0] rep_cnt_d [2];
    logic [1:0]      mv_level;
    logic [1:0]      mv_rise;
    logic [1:0]      mv_strobe;
    logic            both_held;

    // Output stage
    logic drop_d, right_d, left_d;
    logic drop_q, right_q, left_q;

    assign mv_level  = level_q[2:1];
    assign mv_rise   = rise_q[2:1];
    assign both_held = level_q[1] & level_q[2];

    // Two-flop synchronizer for each raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count consecutive mismatch cycles, flip on the last one
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i]  = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Debounce counters and debounced levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            level_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            level_q <= level_d;
        end
    end

    // Registered rising-edge detect; falling edges are deliberately ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_dly_q <= '0;
            rise_q      <= '0;
        end else begin
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
        end
    end

    // Repeat FSM next-state and strobe decode for right and left
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]      = st_q[c];
            rep_cnt_d[c] = rep_cnt_q[c];
            mv_strobe[c] = 1'b0;
            // Release or a right+left conflict drops straight back to idle. Every
            // strobe below therefore implies this button is held and the other is
            // not, so right and left can never strobe together.
            if (!mv_level[c] || both_held) begin
                st_d[c]      = StIdle;
                rep_cnt_d[c] = '0;
            end else begin
                unique case (st_q[c])
                    StIdle: begin
                        if (mv_rise[c]) begin
                            mv_strobe[c] = 1'b1;
                            st_d[c]      = StDelay;
                            rep_cnt_d[c] = '0;
                        end
                    end
                    StDelay: begin
                        if (rep_cnt_q[c] == DelayLast) begin
                            mv_strobe[c] = 1'b1;
                            st_d[c]      = StRepeat;
                            rep_cnt_d[c] = '0;
                        end else begin
                            rep_cnt_d[c] = rep_cnt_q[c] + RepW'(1);
                        end
                    end
                    StRepeat: begin
                        if (rep_cnt_q[c] == RateLast) begin
                            mv_strobe[c] = 1'b1;
                            rep_cnt_d[c] = '0;
                        end else begin
                            rep_cnt_d[c] = rep_cnt_q[c] + RepW'(1);
                        end
                    end
                    default: begin
                        st_d[c]      = StIdle;
                        rep_cnt_d[c] = '0;
                    end
                endcase
            end
        end
    end

    // Repeat FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]      <= StIdle;
                rep_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]      <= st_d[c];
                rep_cnt_q[c] <= rep_cnt_d[c];
            end
        end
    end

    // Output arbitration: drop wins, a colliding move strobe is simply lost
    // while its FSM keeps counting as if it had fired
    always_comb begin
        drop_d  = rise_q[0];
        right_d = mv_strobe[0] & ~drop_d;
        left_d  = mv_strobe[1] & ~drop_d;
    end

    // Registered strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q  <= 1'b0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            drop_q  <= drop_d;
            right_q <= right_d;
            left_q  <= left_d;
        end
    end

    assign drop_pulse  = drop_q;
    assign right_pulse = right_q;
    assign left_pulse  = left_q;
    assign btn_level   = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Cycle n means the DUT state just after the n-th rising edge
// that samples the scenario's stimulus (edge 0 is the first one).
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic       drop_pulse;
    logic       right_pulse;
    logic       left_pulse;
    logic [2:0] btn_level;

    int n_checks;
    int n_errors;
    int cyc;

    localparam logic [2:0] BDrop  = 3'b001;
    localparam logic [2:0] BRight = 3'b010;
    localparam logic [2:0] BLeft  = 3'b100;
    // Pulse vectors are {drop, right, left}
    localparam logic [2:0] PNone  = 3'b000;
    localparam logic [2:0] PDrop  = 3'b100;
    localparam logic [2:0] PRight = 3'b010;
    localparam logic [2:0] PLeft  = 3'b001;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .drop_pulse (drop_pulse),
        .right_pulse(right_pulse),
        .left_pulse (left_pulse),
        .btn_level  (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Entered at a falling edge; drives, waits one rising edge, checks, returns at next fall.
    task automatic run_cycle(input string tag, input logic [2:0] raw, input logic [2:0] exp);
        btn_raw = raw;
        @(posedge clk);
        #1;
        check_eq(tag, {5'b0, drop_pulse, right_pulse, left_pulse}, {5'b0, exp});
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {2'b0, drop_pulse, right_pulse, left_pulse, btn_level}, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_raw = '0;
        rst_n   = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = -1;
        rst_n    = 1'b0;
        btn_raw  = '0;
        #1;
        check_all_zero("rst_initial");

        // Drop held 100 cycles: single strobe at 7, level high from 6
        do_reset();
        for (int c = 0; c < 112; c++) begin
            cyc = c;
            run_cycle("hold_drop", (c < 100) ? BDrop : 3'b000, (c == 7) ? PDrop : PNone);
            if (c <= 4 || c >= 106) check_eq("hold_drop_lvl", {5'b0, btn_level}, 8'h00);
            if (c >= 6 && c <= 104) check_eq("hold_drop_lvl", {5'b0, btn_level}, 8'h01);
        end

        // Drop bounce 1,0,1,0 then steady high: one strobe at 11
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cyc = c;
            run_cycle("bounce_drop", (c == 1 || c == 3) ? 3'b000 : BDrop,
                      (c == 11) ? PDrop : PNone);
        end

        // 3-cycle glitch is shorter than the debounce window: no effect
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc = c;
            run_cycle("glitch3", (c < 3) ? BDrop : 3'b000, PNone);
            check_eq("glitch3_lvl", {5'b0, btn_level}, 8'h00);
        end

        // 4-cycle press just meets the debounce window: strobe at 7
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc = c;
            run_cycle("press4", (c < 4) ? BDrop : 3'b000, (c == 7) ? PDrop : PNone);
        end

        // Right held 60 cycles: press plus auto-repeat, nothing on release
        do_reset();
        for (int c = 0; c < 85; c++) begin
            cyc = c;
            run_cycle("hold_right", (c < 60) ? BRight : 3'b000,
                      (c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59) ?
                      PRight : PNone);
        end

        // Left at 0, right at 10; overlap suppresses everything, no re-strobe after
        do_reset();
        for (int c = 0; c < 110; c++) begin
            cyc = c;
            run_cycle("overlap",
                      ((c < 50) ? BLeft : 3'b000) | ((c >= 10 && c < 90) ? BRight : 3'b000),
                      (c == 7) ? PLeft : PNone);
        end

        // Drop and right together: drop wins at 7, right FSM keeps its timing
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cyc = c;
            run_cycle("drop_right", BDrop | BRight,
                      (c == 7) ? PDrop : ((c == 27 || c == 35) ? PRight : PNone));
        end

        // Right held through a mid-repeat reset: fresh press after release
        do_reset();
        for (int c = 0; c < 30; c++) begin
            cyc = c;
            run_cycle("rst_mid_a", BRight, (c == 7 || c == 27) ? PRight : PNone);
        end
        cyc   = 30;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_async");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all_zero("rst_mid_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cyc = c;
            run_cycle("rst_mid_b", BRight, (c == 7 || c == 27 || c == 35) ? PRight : PNone);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
